// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared types and constants for the memory-side controller that bridges the
//   I-cache and D-side request ports onto a byte-wide synchronous RAM.
//
//   Contents:
//     mem_addr_bus_t  - default-width byte address bus
//     mem_data_bus_t  - 32-bit cache word
//     mem_len_bus_t   - byte count minus one (0 = 1 byte .. 3 = 4 bytes)
//     ram_byte_bus_t  - one RAM byte
//     MEM_IDLE / MEM_READ / MEM_WRITE / MEM_DONE - controller state encodings
//     IO_SPACE / IO_SPACE_LSB - address window of the IO buffer (addr[17:16])
//     word_byte()     - select byte k of a little-endian word
//     is_io_addr()    - true when addr[17:16] selects the IO window
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W_DEFAULT = 32;
  localparam int MEM_DATA_W         = 32;

  typedef logic [MEM_ADDR_W_DEFAULT-1:0] mem_addr_bus_t;
  typedef logic [MEM_DATA_W-1:0]         mem_data_bus_t;
  typedef logic [1:0]                    mem_len_bus_t;
  typedef logic [7:0]                    ram_byte_bus_t;

  localparam logic [1:0] MEM_IDLE  = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;
  localparam logic [1:0] MEM_DONE  = 2'd3;

  localparam logic [1:0] IO_SPACE     = 2'b11;
  localparam int         IO_SPACE_LSB = 16;

  function automatic ram_byte_bus_t word_byte(input mem_data_bus_t w,
                                              input logic [1:0]    k);
    return w[{k, 3'b000} +: 8];
  endfunction

  function automatic logic is_io_addr(input logic [1:0] addr_hi);
    return addr_hi == IO_SPACE;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Memory-side responder for the cache request/busy/ready protocol. Serves a
//   32-bit instruction-fetch port (I) and a 32-bit load/store port (D) over a
//   single byte-wide synchronous RAM. Byte accesses are sequenced one per
//   cycle, read bytes are assembled little-endian, and the D port wins over the
//   I port when both request in the same cycle. All outputs are registered.
//
//   Optional build macro:
//     MEMCTRL_IO_STALL_EN - adds io_buffer_full; D writes into the IO window
//                           (addr[17:16] == 2'b11) hold in WR with ram_wr=0
//                           while the buffer is full and resume at the same
//                           byte once it drains.
//
//   Ports:
//     clock, reset         system clock, synchronous active-high reset
//     io_buffer_full       IO buffer back-pressure (MEMCTRL_IO_STALL_EN only)
//     i_read, i_addr       instruction fetch request (level) and byte address
//     i_busy, i_ready      serving I / one-cycle data-valid pulse
//     i_data               fetched word, valid only in the i_ready cycle
//     d_read, d_write      data read / write request (mutually exclusive)
//     d_addr, d_len        data byte address, byte count minus one
//     d_wdata              write data, little-endian, low bytes used
//     d_busy, d_ready      serving D / one-cycle completion pulse
//     d_rdata              read data, zero above the requested byte count
//     ram_din              RAM read byte, valid the cycle after its address
//     ram_dout, ram_a      RAM write byte and byte address
//     ram_wr               RAM write enable
//
//   State table:
//     state     | meaning
//     ----------+-----------------------------------------------------------
//     MEM_IDLE  | no transfer; arbitrate and accept a request
//     MEM_READ  | issue byte addresses, capture bytes one cycle later
//     MEM_WRITE | drive one byte per cycle with ram_wr=1 (may stall on IO)
//     MEM_DONE  | ready pulse cycle; busy still high; may accept next request
// -----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
`ifdef MEMCTRL_IO_STALL_EN
  input  logic              io_buffer_full,
`endif
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_busy,
  output logic              i_ready,
  output logic [31:0]       i_data,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_len,
  input  logic [31:0]       d_wdata,
  output logic              d_busy,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  logic [1:0]        state;
  logic              serve_d;
  logic [ADDR_W-1:0] base;
  mem_len_bus_t      last;
  mem_data_bus_t     wdata_q;
  mem_data_bus_t     acc;

  // Shared sequencing counter. In MEM_READ it is the current cycle number
  // (1-based) of the transfer; in MEM_WRITE it is the index of the next byte
  // to put on the RAM pins.
  logic [2:0]        cnt;

  logic [2:0]        last_ext;
  logic [ADDR_W-1:0] addr_k;
  logic [1:0]        cap_k;
  mem_data_bus_t     acc_next;
  logic              stall;
  logic              stall_accept;

  assign last_ext = {1'b0, last};
  assign addr_k   = base + ADDR_W'(cnt);

  // ram_din in cycle c carries the byte addressed in cycle c-1, i.e. byte c-2.
  assign cap_k    = cnt[1:0] - 2'd2;
  assign acc_next = acc | (32'(ram_din) << {cap_k, 3'b000});

`ifdef MEMCTRL_IO_STALL_EN
  assign stall        = io_buffer_full && is_io_addr(base[IO_SPACE_LSB+1:IO_SPACE_LSB]);
  assign stall_accept = io_buffer_full && is_io_addr(d_addr[IO_SPACE_LSB+1:IO_SPACE_LSB]);
`else
  assign stall        = 1'b0;
  assign stall_accept = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= MEM_IDLE;
      serve_d  <= 1'b0;
      base     <= '0;
      last     <= '0;
      wdata_q  <= '0;
      acc      <= '0;
      cnt      <= '0;
      i_busy   <= 1'b0;
      i_ready  <= 1'b0;
      i_data   <= '0;
      d_busy   <= 1'b0;
      d_ready  <= 1'b0;
      d_rdata  <= '0;
      ram_dout <= '0;
      ram_a    <= '0;
      ram_wr   <= 1'b0;
    end else begin
      // Pulses and data outputs are only non-zero for the single cycle the
      // transfer logic below asks for.
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_data  <= '0;
      d_rdata <= '0;
      ram_wr  <= 1'b0;

      case (state)
        // The edge ending DONE behaves like IDLE so a waiting port can be
        // accepted back-to-back without an idle bubble.
        MEM_IDLE, MEM_DONE: begin
          state  <= MEM_IDLE;
          i_busy <= 1'b0;
          d_busy <= 1'b0;
          if (d_write) begin
            state   <= MEM_WRITE;
            serve_d <= 1'b1;
            d_busy  <= 1'b1;
            base    <= d_addr;
            last    <= d_len;
            wdata_q <= d_wdata;
            acc     <= '0;
            ram_a   <= d_addr;
            if (stall_accept) begin
              cnt <= 3'd0;
            end else begin
              ram_wr   <= 1'b1;
              ram_dout <= d_wdata[7:0];
              cnt      <= 3'd1;
            end
          end else if (d_read) begin
            state   <= MEM_READ;
            serve_d <= 1'b1;
            d_busy  <= 1'b1;
            base    <= d_addr;
            last    <= d_len;
            acc     <= '0;
            ram_a   <= d_addr;
            cnt     <= 3'd1;
          end else if (i_read) begin
            state   <= MEM_READ;
            serve_d <= 1'b0;
            i_busy  <= 1'b1;
            base    <= i_addr;
            last    <= 2'd3;
            acc     <= '0;
            ram_a   <= i_addr;
            cnt     <= 3'd1;
          end
        end

        MEM_READ: begin
          if (cnt <= last_ext) begin
            ram_a <= addr_k;
          end
          if (cnt >= 3'd2) begin
            acc <= acc_next;
          end
          // Last byte lands at the end of cycle n+1; present the word in n+2.
          if (cnt == last_ext + 3'd2) begin
            state <= MEM_DONE;
            if (serve_d) begin
              d_ready <= 1'b1;
              d_rdata <= acc_next;
            end else begin
              i_ready <= 1'b1;
              i_data  <= acc_next;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        MEM_WRITE: begin
          if (cnt == last_ext + 3'd1) begin
            state   <= MEM_DONE;
            d_ready <= 1'b1;
          end else if (!stall) begin
            ram_wr   <= 1'b1;
            ram_a    <= addr_k;
            ram_dout <= word_byte(wdata_q, cnt[1:0]);
            cnt      <= cnt + 3'd1;
          end
        end

        default: begin
          state <= MEM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_read;
  logic [31:0] i_addr;
  logic        i_busy, i_ready;
  logic [31:0] i_data;
  logic        d_read, d_write;
  logic [31:0] d_addr;
  logic [1:0]  d_len;
  logic [31:0] d_wdata;
  logic        d_busy, d_ready;
  logic [31:0] d_rdata;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
`ifdef MEMCTRL_IO_STALL_EN
  logic        io_buffer_full;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clock    (clock),
    .reset    (reset),
`ifdef MEMCTRL_IO_STALL_EN
    .io_buffer_full(io_buffer_full),
`endif
    .i_read   (i_read),
    .i_addr   (i_addr),
    .i_busy   (i_busy),
    .i_ready  (i_ready),
    .i_data   (i_data),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_len    (d_len),
    .d_wdata  (d_wdata),
    .d_busy   (d_busy),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .ram_a    (ram_a),
    .ram_wr   (ram_wr)
  );

  always #5 clock = ~clock;

  // Byte RAM, 64 KiB aliased on the low address bits; read-first.
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        poke_en;
  logic [15:0] poke_a;
  logic [7:0]  poke_d;

  always @(posedge clock) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (ram_wr) mem[ram_a[15:0]] <= ram_dout;
    ram_din <= mem[ram_a[15:0]];
  end

  logic [108:0] outs;
  assign outs = {i_busy, i_ready, i_data, d_busy, d_ready, d_rdata, ram_dout, ram_a, ram_wr};

  // Per-cycle trace of one transfer, cycle 1 = first cycle after accept.
  logic [31:0] tr_a  [1:16];
  logic        tr_wr [1:16];
  logic [7:0]  tr_do [1:16];
  logic        tr_ib [1:16];
  logic        tr_db [1:16];
  logic        tr_ir [1:16];
  logic        tr_dr [1:16];
  logic [31:0] tr_id [1:16];
  logic [31:0] tr_dd [1:16];
  logic [108:0] tr_out [1:16];

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    poke_en = 1'b1;
    poke_a  = a[15:0];
    poke_d  = v;
    ref_mem[a[15:0]] = v;
    @(posedge clock); #1;
    poke_en = 1'b0;
  endtask

  // Called just after a posedge with requests already driven; the next edge
  // is the accept edge.
  task automatic capture(input int ncyc, input int i_drop, input int rst_cyc);
    @(posedge clock); #1;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == rst_cyc) reset = 1'b1;
      @(negedge clock);
      tr_a[c] = ram_a;   tr_wr[c] = ram_wr;  tr_do[c] = ram_dout;
      tr_ib[c] = i_busy; tr_db[c] = d_busy;  tr_ir[c] = i_ready;
      tr_dr[c] = d_ready; tr_id[c] = i_data; tr_dd[c] = d_rdata;
      tr_out[c] = outs;
      @(posedge clock); #1;
      if (c == 1) begin d_read = 1'b0; d_write = 1'b0; end
      if (c == i_drop) i_read = 1'b0;
      if (c == rst_cyc) reset = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a, input int n);
    logic [31:0] w = 32'h0;
    logic [31:0] ak;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      w  = w | (32'(ref_mem[ak[15:0]]) << (8 * k));
    end
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_tests++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h expected 0", outs);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    n_tests++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL idle_after_reset got %h expected 0", outs);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_fetch();
    logic [34:0] got, exp;
    poke(32'h100, 8'h11); poke(32'h101, 8'h22);
    poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    i_read = 1'b1; i_addr = 32'h100;
    capture(7, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      n_tests++;
      if (tr_a[c] !== 32'h100 + 32'(c - 1) || tr_wr[c] !== 1'b0) begin
        n_fail++; $display("FAIL fetch_addr cyc %0d got a=%h wr=%b expected a=%h wr=0", c, tr_a[c], tr_wr[c], 32'h100 + 32'(c - 1));
      end
    end
    for (int c = 1; c <= 7; c++) begin
      got = {tr_ib[c], tr_ir[c], tr_db[c], tr_id[c]};
      exp = {c <= 6, c == 6, 1'b0, (c == 6) ? 32'h44332211 : 32'h0};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL fetch_resp cyc %0d got %h expected %h", c, got, exp);
      end
    end
  endtask

  task automatic test_write();
    logic [42:0] got, exp;
    poke(32'h202, 8'h5A);
    d_write = 1'b1; d_addr = 32'h200; d_len = 2'd1; d_wdata = 32'hDEADBEEF;
    capture(4, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      got = {tr_wr[c], (c <= 2) ? tr_a[c] : 32'h0, tr_wr[c] ? tr_do[c] : 8'h0, tr_dr[c], tr_db[c]};
      exp = {c <= 2, (c == 1) ? 32'h200 : (c == 2) ? 32'h201 : 32'h0,
             (c == 1) ? 8'hEF : (c == 2) ? 8'hBE : 8'h0, c == 3, c <= 3};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL write_cycle cyc %0d got %h expected %h", c, got, exp);
      end
    end
    n_tests++;
    if ({mem[16'h200], mem[16'h201], mem[16'h202]} !== 24'hEFBE5A) begin
      n_fail++; $display("FAIL write_mem got %h expected efbe5a", {mem[16'h200], mem[16'h201], mem[16'h202]});
    end
  endtask

  task automatic test_arbitration();
    logic [69:0] got, exp;
    logic [31:0] w;
    poke(32'h10, 8'h80);
    for (int k = 0; k < 4; k++) poke(32'h400 + 32'(k), 8'($urandom));
    w = model_word(32'h400, 4);
    i_read = 1'b1; i_addr = 32'h400;
    d_read = 1'b1; d_addr = 32'h10; d_len = 2'd0;
    capture(10, 4, 0);
    n_tests++;
    if (tr_a[1] !== 32'h10) begin
      n_fail++; $display("FAIL arb_first_addr got %h expected 00000010", tr_a[1]);
    end
    for (int c = 1; c <= 10; c++) begin
      got = {tr_ib[c], tr_db[c], tr_ir[c], tr_dr[c], tr_id[c], tr_dd[c]};
      exp = {c >= 4 && c <= 9, c <= 3, c == 9, c == 3,
             (c == 9) ? w : 32'h0, (c == 3) ? 32'h80 : 32'h0};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL arb_cycle cyc %0d got %h expected %h", c, got, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    poke(32'hFFFFFFFE, 8'hA1); poke(32'hFFFFFFFF, 8'hB2);
    poke(32'h00000000, 8'hC3); poke(32'h00000001, 8'hD4);
    w = model_word(32'hFFFFFFFE, 4);
    i_read = 1'b1; i_addr = 32'hFFFFFFFE;
    capture(7, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      n_tests++;
      if (tr_a[c] !== 32'hFFFFFFFE + 32'(c - 1)) begin
        n_fail++; $display("FAIL wrap_addr cyc %0d got %h expected %h", c, tr_a[c], 32'hFFFFFFFE + 32'(c - 1));
      end
    end
    n_tests++;
    if (tr_ir[6] !== 1'b1 || tr_id[6] !== w) begin
      n_fail++; $display("FAIL wrap_data got ready=%b data=%h expected ready=1 data=%h", tr_ir[6], tr_id[6], w);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    logic        any_ready;
    poke(32'h300, 8'h01); poke(32'h301, 8'h02);
    poke(32'h302, 8'h03); poke(32'h303, 8'h04);
    d_write = 1'b1; d_addr = 32'h300; d_len = 2'd3; d_wdata = 32'h11223344;
    capture(8, 1, 2);
    n_tests++;
    if ({tr_wr[1], tr_wr[2]} !== 2'b11) begin
      n_fail++; $display("FAIL rstmid_wr_before got %b expected 11", {tr_wr[1], tr_wr[2]});
    end
    any_ready = 1'b0;
    for (int c = 1; c <= 8; c++) any_ready = any_ready | tr_dr[c];
    n_tests++;
    if (any_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_ready got %b expected 0", any_ready);
    end
    for (int c = 3; c <= 8; c++) begin
      n_tests++;
      if (tr_out[c] !== '0) begin
        n_fail++; $display("FAIL rstmid_outputs cyc %0d got %h expected 0", c, tr_out[c]);
      end
    end
    ref_mem[16'h300] = 8'h44;
    ref_mem[16'h301] = 8'h33;
    n_tests++;
    if ({mem[16'h300], mem[16'h301], mem[16'h302], mem[16'h303]} !== 32'h44330304) begin
      n_fail++; $display("FAIL rstmid_mem got %h expected 44330304", {mem[16'h300], mem[16'h301], mem[16'h302], mem[16'h303]});
    end
    w = model_word(32'h300, 4);
    i_read = 1'b1; i_addr = 32'h300;
    capture(7, 1, 0);
    n_tests++;
    if (tr_ir[6] !== 1'b1 || tr_id[6] !== w || tr_ib[7] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_fetch got ready=%b data=%h expected ready=1 data=%h", tr_ir[6], tr_id[6], w);
    end
  endtask

  task automatic test_random();
    int          kind, n, lat, ncyc;
    logic [31:0] addr, wd, exp_w, ak, sh;
    logic [1:0]  len;
    logic        is_d, wr;
    logic [68:0] got_v, exp_v;
    logic [39:0] got_a, exp_a;
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 2));
      addr = $urandom;
      if (t % 5 == 0) addr = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
      is_d = (kind != 0);
      wr   = (kind == 2);
      len  = is_d ? 2'($urandom_range(0, 3)) : 2'd3;
      n    = int'(len) + 1;
      wd   = $urandom;
      if (!wr) for (int k = 0; k < n; k++) poke(addr + 32'(k), 8'($urandom));
      exp_w = model_word(addr, n);
      lat   = wr ? n + 1 : n + 2;
      ncyc  = lat + 1;
      if (!is_d) begin
        i_read = 1'b1; i_addr = addr;
      end else begin
        d_read = !wr; d_write = wr; d_addr = addr; d_len = len; d_wdata = wd;
      end
      capture(ncyc, 1, 0);
      for (int c = 1; c <= ncyc; c++) begin
        got_v = {tr_ib[c], tr_db[c], tr_ir[c], tr_dr[c], tr_wr[c], tr_id[c], tr_dd[c]};
        exp_v = {!is_d && c <= lat, is_d && c <= lat, !is_d && c == lat, is_d && c == lat,
                 wr && c <= n,
                 (!is_d && c == lat) ? exp_w : 32'h0,
                 (is_d && !wr && c == lat) ? exp_w : 32'h0};
        n_tests++;
        if (got_v !== exp_v) begin
          n_fail++; $display("FAIL rand_cycle txn %0d cyc %0d got %h expected %h", t, c, got_v, exp_v);
        end
        if (c <= n) begin
          sh    = wd >> (8 * (c - 1));
          got_a = {tr_a[c], wr ? tr_do[c] : 8'h0};
          exp_a = {addr + 32'(c - 1), wr ? sh[7:0] : 8'h0};
          n_tests++;
          if (got_a !== exp_a) begin
            n_fail++; $display("FAIL rand_addr txn %0d cyc %0d got %h expected %h", t, c, got_a, exp_a);
          end
        end
      end
      if (wr) begin
        for (int k = 0; k < n; k++) begin
          ak = addr + 32'(k);
          sh = wd >> (8 * k);
          ref_mem[ak[15:0]] = sh[7:0];
        end
        for (int k = -1; k <= n; k++) begin
          ak = addr + 32'(k);
          n_tests++;
          if (mem[ak[15:0]] !== ref_mem[ak[15:0]]) begin
            n_fail++; $display("FAIL rand_mem txn %0d addr %h got %h expected %h", t, ak, mem[ak[15:0]], ref_mem[ak[15:0]]);
          end
        end
      end
    end
  endtask

`ifdef MEMCTRL_IO_STALL_EN
  task automatic test_io_stall();
    logic [43:0] got, exp;
    io_buffer_full = 1'b1;
    d_write = 1'b1; d_addr = 32'h30000; d_len = 2'd0; d_wdata = 32'h000000A5;
    @(posedge clock); #1;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) d_write = 1'b0;
      if (c == 5) io_buffer_full = 1'b0;
      @(negedge clock);
      got = {ram_wr, ram_wr ? ram_a : 32'h0, ram_wr ? ram_dout : 8'h0, d_ready, d_busy};
      exp = {c == 6, (c == 6) ? 32'h30000 : 32'h0, (c == 6) ? 8'hA5 : 8'h0, c == 7, c <= 7};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL io_stall cyc %0d got %h expected %h", c, got, exp);
      end
      @(posedge clock); #1;
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_len = '0; d_wdata = '0;
    poke_en = 1'b0; poke_a = '0; poke_d = '0;
`ifdef MEMCTRL_IO_STALL_EN
    io_buffer_full = 1'b0;
`endif
    #1;
    test_reset();
    test_fetch();
    test_write();
    test_arbitration();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef MEMCTRL_IO_STALL_EN
    test_io_stall();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
